// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and constants for the Muldiv sequencer
package muldiv_pkg;
    typedef enum logic [1:0] {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU} op_e;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_e;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/result and Muldiv-side signals of the sequencer
interface muldiv_seq_if;
    logic        flush;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_err;
    logic        md_rst_n;
    logic        md_valid;
    logic        md_mode;
    logic [31:0] md_in_a;
    logic [31:0] md_in_b;
    logic        md_ready;
    logic [63:0] md_out;
    modport slave (
        input  flush, req_valid, req_op, op_a, op_b, md_ready, md_out,
        output stall, res_valid, res_data, res_err, md_rst_n, md_valid, md_mode, md_in_a, md_in_b
    );
    modport master (
        output flush, req_valid, req_op, op_a, op_b, md_ready, md_out,
        input  stall, res_valid, res_data, res_err, md_rst_n, md_valid, md_mode, md_in_a, md_in_b
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: launches one Muldiv operation per instruction and stalls until its result
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input logic         clk,
    input logic         rst,
    muldiv_seq_if.slave bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_q, a_d, b_q, b_d, data_q, data_d;
    logic          mode_q, mode_d, err_q, err_d;
    logic          md_valid_q, md_valid_d, md_rst_n_q, md_rst_n_d, res_valid_q, res_valid_d;
    logic          abort;
    assign abort = bus.flush || !bus.req_valid;
    // next state, operand latching, watchdog and result capture
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        data_d  = '0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: if (bus.req_valid && !bus.flush) begin
                op_d   = op_e'(bus.req_op);
                a_d    = bus.op_a;
                b_d    = bus.op_b;
                mode_d = bus.req_op[1] ? MD_DIV : MD_MUL;
                if (bus.req_op[1] && bus.op_b == '0) begin
                    state_d = S_DONE;
                    data_d  = (bus.req_op == OP_REMU) ? bus.op_a : DIV0_QUOT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = abort ? S_IDLE : S_BUSY;
            end
            S_BUSY: if (abort) begin
                state_d = S_IDLE;
            end else if (bus.md_ready) begin
                state_d = S_DONE;
                data_d  = (op_q inside {OP_MULHU, OP_REMU}) ? bus.md_out[63:32] : bus.md_out[31:0];
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                state_d = S_DONE;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        md_valid_d  = state_d == S_ISSUE;
        md_rst_n_d  = state_d inside {S_ISSUE, S_BUSY};
        res_valid_d = state_d == S_DONE;
    end
    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_MUL;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= MD_MUL;
            data_q      <= '0;
            err_q       <= 1'b0;
            md_valid_q  <= 1'b0;
            md_rst_n_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            data_q      <= data_d;
            err_q       <= err_d;
            md_valid_q  <= md_valid_d;
            md_rst_n_q  <= md_rst_n_d;
            res_valid_q <= res_valid_d;
        end
    end
    assign bus.stall     = !rst && bus.req_valid && state_q != S_DONE;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = data_q;
    assign bus.res_err   = err_q;
    assign bus.md_rst_n  = md_rst_n_q;
    assign bus.md_valid  = md_valid_q;
    assign bus.md_mode   = mode_q;
    assign bus.md_in_a   = a_q;
    assign bus.md_in_b   = b_q;
endmodule
